// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, read-only L1 cache with a single-outstanding miss controller in front of the L2.
// Optional hit/miss statistics counters are built only when L1_STATS_EN is defined.
module l1_cache_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int CACHE_SIZE = 128,
    parameter int BLOCK_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_ready,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_data,
    output logic                  cpu_resp_l1_hit,
    output logic                  cpu_resp_l2_hit,
    output logic                  l2_read,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    input  logic [DATA_WIDTH-1:0] l2_read_data,
    input  logic                  l2_hit,
    output logic [15:0]           stat_hits,
    output logic [15:0]           stat_misses
);

    localparam int NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
    localparam int OFFSET_W  = $clog2(BLOCK_SIZE);
    localparam int INDEX_W   = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_WIDTH - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        L2_REQ,
        L2_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [INDEX_W-1:0]      req_index;
    logic [TAG_W-1:0]        req_tag;
    logic                    accept;
    logic                    lookup_hit;

    logic [NUM_LINES-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0]   data_q [NUM_LINES];

    // Offset bits only reach the L2; the lookup uses index and tag alone.
    assign req_index  = req_addr[OFFSET_W +: INDEX_W];
    assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign cpu_ready  = (state == IDLE) && rst_n;
    assign accept     = cpu_req && cpu_ready;
    assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit ? IDLE : L2_REQ;
            L2_REQ:  state_next = L2_WAIT;
            L2_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr <= '0;
        end else if (accept) begin
            req_addr <= cpu_addr;
        end
    end

    // The fill overwrites the indexed line unconditionally, even with the L2-miss pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (state == L2_WAIT) begin
            valid_q[req_index] <= 1'b1;
            tag_q[req_index]   <= req_tag;
            data_q[req_index]  <= l2_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_resp_valid  <= 1'b0;
            cpu_resp_data   <= '0;
            cpu_resp_l1_hit <= 1'b0;
            cpu_resp_l2_hit <= 1'b0;
            l2_read         <= 1'b0;
            l2_addr         <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            l2_read        <= 1'b0;
            case (state)
                LOOKUP: begin
                    if (lookup_hit) begin
                        cpu_resp_valid  <= 1'b1;
                        cpu_resp_data   <= data_q[req_index];
                        cpu_resp_l1_hit <= 1'b1;
                        cpu_resp_l2_hit <= 1'b0;
                    end else begin
                        l2_read <= 1'b1;
                        l2_addr <= req_addr;
                    end
                end
                L2_WAIT: begin
                    cpu_resp_valid  <= 1'b1;
                    cpu_resp_data   <= l2_read_data;
                    cpu_resp_l1_hit <= 1'b0;
                    cpu_resp_l2_hit <= l2_hit;
                end
                default: ;
            endcase
        end
    end

`ifdef L1_STATS_EN
    logic hit_event;
    logic miss_event;

    assign hit_event  = (state == LOOKUP) && lookup_hit;
    assign miss_event = (state == L2_WAIT);

    // Counters saturate rather than wrap so long runs never report small totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit_event && (stat_hits != 16'hFFFF)) begin
                stat_hits <= stat_hits + 16'd1;
            end
            if (miss_event && (stat_misses != 16'hFFFF)) begin
                stat_misses <= stat_misses + 16'd1;
            end
        end
    end
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
